// File: rtl/systolic_skew_feeder.sv
// Skews a DEPTH-word block into a systolic array one row per cycle, then drains and requests the next block.
// Optional sticky overrun flag: define SKEW_FEEDER_OVERRUN_EN.
module systolic_skew_feeder #(
    parameter int unsigned PE_DATA_WIDTH = 16,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned DRAIN         = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PE_DATA_WIDTH*DEPTH-1:0]   data_in,
    input  logic                             data_valid,
    input  logic                             loader_done,
    output logic [PE_DATA_WIDTH*DEPTH-1:0]   pe_row_data,
    output logic [DEPTH-1:0]                 pe_row_valid,
    output logic                             tpu_ready,
    output logic                             all_done,
    output logic                             overrun
);

    localparam int unsigned BW  = PE_DATA_WIDTH * DEPTH;
    localparam int unsigned FCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [FCW-1:0] FEED_LAST  = FCW'(DEPTH - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_READY = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [BW-1:0]    buf_q, buf_d;
    logic [FCW-1:0]   feed_cnt_q, feed_cnt_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic             dv_q;
    logic             done_pending_q, done_pending_d;
    logic [BW-1:0]    pe_row_data_q, pe_row_data_d;
    logic [DEPTH-1:0] pe_row_valid_q, pe_row_valid_d;
    logic             tpu_ready_q, tpu_ready_d;
    logic             all_done_q, all_done_d;
    logic             rise;

    // Only a low-to-high transition of the valid level counts as a new block
    assign rise = data_valid & ~dv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        feed_cnt_d  = feed_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d    = S_FEED;
                    buf_d      = data_in;
                    feed_cnt_d = '0;
                end
            end
            S_FEED: begin
                if (feed_cnt_q == FEED_LAST) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    feed_cnt_d = feed_cnt_q + FCW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_READY;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            S_READY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pe_row_data_d  = '0;
        pe_row_valid_d = '0;
        tpu_ready_d    = 1'b0;
        all_done_d     = all_done_q;
        done_pending_d = done_pending_q | loader_done;
        case (state_q)
            S_IDLE: begin
                // A new block wins over completion; a pending done is kept for its end
                if (rise) begin
                    all_done_d = 1'b0;
                end else if (done_pending_d) begin
                    all_done_d     = 1'b1;
                    done_pending_d = 1'b0;
                end
            end
            S_FEED: begin
                for (int unsigned r = 0; r < DEPTH; r++) begin
                    if (FCW'(r) == feed_cnt_q) begin
                        pe_row_valid_d[r] = 1'b1;
                        pe_row_data_d[r*PE_DATA_WIDTH +: PE_DATA_WIDTH] =
                            buf_q[r*PE_DATA_WIDTH +: PE_DATA_WIDTH];
                    end
                end
            end
            S_READY: tpu_ready_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q          <= '0;
            feed_cnt_q     <= '0;
            drain_cnt_q    <= '0;
            dv_q           <= 1'b0;
            done_pending_q <= 1'b0;
            pe_row_data_q  <= '0;
            pe_row_valid_q <= '0;
            tpu_ready_q    <= 1'b0;
            all_done_q     <= 1'b0;
        end else begin
            buf_q          <= buf_d;
            feed_cnt_q     <= feed_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            dv_q           <= data_valid;
            done_pending_q <= done_pending_d;
            pe_row_data_q  <= pe_row_data_d;
            pe_row_valid_q <= pe_row_valid_d;
            tpu_ready_q    <= tpu_ready_d;
            all_done_q     <= all_done_d;
        end
    end

    assign pe_row_data  = pe_row_data_q;
    assign pe_row_valid = pe_row_valid_q;
    assign tpu_ready    = tpu_ready_q;
    assign all_done     = all_done_q;

`ifdef SKEW_FEEDER_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky record of any block edge that arrived while busy
    always_comb begin
        overrun_d = overrun_q | (rise & (state_q != S_IDLE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: a timing-level model queues expected rows and ready pulses.
module tb_systolic_skew_feeder;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int DR = 4;
    localparam int BW = W * D;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] data_in;
    logic          data_valid;
    logic          loader_done;
    logic [BW-1:0] pe_row_data;
    logic [D-1:0]  pe_row_valid;
    logic          tpu_ready;
    logic          all_done;
    logic          overrun;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.PE_DATA_WIDTH(W), .DEPTH(D), .DRAIN(DR)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .loader_done  (loader_done),
        .pe_row_data  (pe_row_data),
        .pe_row_valid (pe_row_valid),
        .tpu_ready    (tpu_ready),
        .all_done     (all_done),
        .overrun      (overrun)
    );

    typedef struct {
        int            due;
        int            row;
        logic [BW-1:0] data;
    } row_t;

    row_t rq[$];
    int   tq[$];
    int   ecount     = 0;
    int   busy_until = -1;
    logic prev_dv    = 1'b0;
    logic all_done_m = 1'b0;
    logic ovr_m      = 1'b0;
    logic pend_m     = 1'b0;
    int   n_tests    = 0;
    int   n_fail     = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, ecount);
        end
    endtask

    task automatic record_fail(input string name, input int exp_edge);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event expected at edge %0d, seen at edge %0d", name, exp_edge, ecount);
    endtask

    // Reference model: a block accepted at edge e shows row k after edge e+1+k and
    // ready after edge e+D+DR+1; the feeder is busy through that last edge.
    initial begin
        logic rise;
        logic idle;
        row_t it;
        forever begin
            @(posedge clk);
            ecount++;
            if (reset) begin
                rq.delete();
                tq.delete();
                busy_until = -1;
                prev_dv    = 1'b0;
                all_done_m = 1'b0;
                ovr_m      = 1'b0;
                pend_m     = 1'b0;
            end else begin
                rise = data_valid && !prev_dv;
                idle = ecount > busy_until;
                if (rise && idle) begin
                    for (int k = 0; k < D; k++) begin
                        it.due  = ecount + 1 + k;
                        it.row  = k;
                        it.data = '0;
                        it.data[k*W +: W] = data_in[k*W +: W];
                        rq.push_back(it);
                    end
                    tq.push_back(ecount + D + DR + 1);
                    busy_until = ecount + D + DR + 1;
                    all_done_m = 1'b0;
                    pend_m     = pend_m | loader_done;
                end else begin
`ifdef SKEW_FEEDER_OVERRUN_EN
                    if (rise) ovr_m = 1'b1;
`endif
                    pend_m = pend_m | loader_done;
                    if (idle && pend_m) begin
                        all_done_m = 1'b1;
                        pend_m     = 1'b0;
                    end
                end
                prev_dv = data_valid;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a row or a ready pulse
    initial begin
        row_t it;
        int   due;
        logic [BW-1:0] one;
        forever begin
            @(negedge clk);
            if (ecount > 0) begin
                while (rq.size() > 0 && rq[0].due < ecount) begin
                    it = rq.pop_front();
                    record_fail("row_missing", it.due);
                end
                if (pe_row_valid != '0) begin
                    if (rq.size() == 0) begin
                        record_fail("row_unexpected", -1);
                    end else begin
                        it  = rq.pop_front();
                        one = BW'(1);
                        check("row_edge", BW'(ecount), BW'(it.due));
                        check("row_valid", BW'(pe_row_valid), one << it.row);
                        check("row_data", pe_row_data, it.data);
                    end
                end else begin
                    check("row_data_idle", pe_row_data, '0);
                end
                while (tq.size() > 0 && tq[0] < ecount) begin
                    due = tq.pop_front();
                    record_fail("ready_missing", due);
                end
                if (tpu_ready) begin
                    if (tq.size() == 0) begin
                        record_fail("ready_unexpected", -1);
                    end else begin
                        due = tq.pop_front();
                        check("ready_edge", BW'(ecount), BW'(due));
                    end
                end
                check("all_done", BW'(all_done), BW'(all_done_m));
                check("overrun", BW'(overrun), BW'(ovr_m));
            end
        end
    end

    task automatic drive(input logic dv, input logic ld, input logic rst, input logic [BW-1:0] d);
        data_valid  = dv;
        loader_done = ld;
        reset       = rst;
        data_in     = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] v;
        for (int i = 0; i < D; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic idle_for(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rand_block());
    endtask

    initial begin
        logic dv;
        repeat (3) drive(1'b0, 1'b0, 1'b1, '0);
        idle_for(2);

        // Directed block 1,2,3,4
        drive(1'b1, 1'b0, 1'b0, 64'h0004_0003_0002_0001);
        idle_for(14);

        // Level held high: one block only
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, rand_block());
        idle_for(12);

        // Second edge while feeding row 2 is dropped
        drive(1'b1, 1'b0, 1'b0, rand_block());
        idle_for(2);
        drive(1'b1, 1'b0, 1'b0, rand_block());
        idle_for(14);

        // Final block with loader_done during FEED; all_done holds until next edge
        drive(1'b1, 1'b0, 1'b0, rand_block());
        idle_for(1);
        drive(1'b0, 1'b1, 1'b0, rand_block());
        idle_for(15);
        drive(1'b1, 1'b0, 1'b0, rand_block());
        idle_for(14);

        // loader_done while idle
        drive(1'b0, 1'b1, 1'b0, rand_block());
        idle_for(4);

        // Reset during DRAIN aborts, then a fresh block feeds normally
        drive(1'b1, 1'b0, 1'b0, rand_block());
        idle_for(6);
        drive(1'b0, 1'b0, 1'b1, rand_block());
        idle_for(2);
        drive(1'b1, 1'b0, 1'b0, rand_block());
        idle_for(14);

        // Random traffic
        dv = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) dv = ~dv;
            drive(dv, ($urandom_range(0, 40) == 0), ($urandom_range(0, 150) == 0), rand_block());
        end
        idle_for(20);

        check("rows_left", BW'(rq.size()), '0);
        check("ready_left", BW'(tq.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 SHALL have parameter PE_DATA_WIDTH, default 16, meaning the width of one pixel word.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of systolic rows and the number of words per block.
REQ-003 SHALL have parameter DRAIN, default 4, meaning the number of cycles the array needs to flush after the last row is fed.
REQ-004 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port: data_in  input  PE_DATA_WIDTH*DEPTH  packed block from the upstream loader; word r is bits [r*PE_DATA_WIDTH +: PE_DATA_WIDTH].
REQ-007 SHALL have port: data_valid  input  1  upstream block-valid level; it may stay high for many cycles.
REQ-008 SHALL have port: loader_done  input  1  upstream single-cycle end-of-image pulse.
REQ-009 SHALL have port: pe_row_data  output  PE_DATA_WIDTH*DEPTH  skewed row inputs to the array, row r in slice r.
REQ-010 SHALL have port: pe_row_valid  output  DEPTH  per-row valid flags.
REQ-011 SHALL have port: tpu_ready  output  1  single-cycle pulse requesting the next block.
REQ-012 SHALL have port: all_done  output  1  level; the image is fully fed and drained.
REQ-013 SHALL have port: overrun  output  1  sticky flag; a block arrived while busy.

Function
REQ-014 SHALL register data_valid into dv_q and detect a block arrival as data_valid & ~dv_q (rising edge); a level held high SHALL NOT be re-accepted.
REQ-015 SHALL use FSM states IDLE, FEED, DRAIN, READY.
REQ-016 In IDLE, on a rising edge the block SHALL transition to FEED, capture data_in into a DEPTH-word buffer, clear feed_cnt, and clear all_done.
REQ-017 In FEED, on the cycle with feed_cnt==k (k=0..DEPTH-1): pe_row_valid SHALL be one-hot at bit k, slice k SHALL carry buffer word k, and all other slices SHALL be 0.
REQ-018 Outputs SHALL be registered: the first row valid appears on the cycle after the capture edge, so latency from data_valid rising to pe_row_valid[0] is 2 clocks.
REQ-019 FEED SHALL last exactly DEPTH cycles and then transition to DRAIN; DRAIN SHALL last exactly DRAIN cycles with pe_row_valid=0 and pe_row_data=0, then transition to READY.
REQ-020 READY SHALL last one cycle, assert tpu_ready for exactly that cycle, and return to IDLE.
REQ-021 The loader_done pulse, in any state, SHALL set done_pending.
REQ-022 On entering IDLE from READY with done_pending set, all_done SHALL assert and done_pending SHALL clear.
REQ-023 If loader_done arrives while in IDLE, all_done SHALL assert on the next cycle.
REQ-024 all_done SHALL hold until reset or the next accepted block.
REQ-025 A rising edge of data_valid seen in FEED, DRAIN or READY SHALL be dropped, with the buffer unchanged, and SHALL set overrun (per Configuration).
REQ-026 A rising edge in the same cycle as the READY-to-IDLE transition SHALL count as busy (dropped).
REQ-027 Counters SHALL be $clog2 sized with no wrap beyond their terminal counts; data SHALL pass unmodified (no arithmetic).

Reset
REQ-028 While reset is high: state SHALL be IDLE; buffer, feed/drain counters, dv_q, done_pending, pe_row_data, pe_row_valid, tpu_ready, all_done and overrun SHALL all be 0.
REQ-029 Reset mid-FEED or mid-DRAIN SHALL abort the block with no tpu_ready pulse.
REQ-030 The first data_valid high after reset release SHALL count as a rising edge.

Configuration
REQ-031 With macro SKEW_FEEDER_OVERRUN_EN defined, overrun SHALL be a sticky register set per REQ-025 and cleared only by reset.
REQ-032 Without SKEW_FEEDER_OVERRUN_EN, no overrun register SHALL exist, overrun SHALL be constant 0, and drops SHALL still occur silently.

Verification
REQ-033 Reset, then data_valid rises with data_in=0x0004_0003_0002_0001 -> pe_row_valid 0001,0010,0100,1000 on cycles +2..+5; slice values 1,2,3,4; tpu_ready pulses at cycle +10 (DRAIN=4).
REQ-034 data_valid held high for 20 cycles -> exactly one block fed and exactly one tpu_ready pulse.
REQ-035 A second rising edge at feed_cnt=2 -> second block dropped, rows still show the first block; overrun=1 with the macro, 0 without.
REQ-036 Final block followed by a loader_done pulse during FEED -> all_done=1 on the cycle after the tpu_ready pulse, and it stays 1 until the next rising edge.
REQ-037 Reset asserted during DRAIN -> all outputs 0 on the next cycle, no tpu_ready; a fresh block afterwards is fed normally.
